id_ex_stage: RTL and testbench

//  ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the decoder
//  and register file. It captures control and operand data, then presents them to EX one cycle later.
//  It contains the load-use hazard detector. On a hazard it inserts a bubble and asserts stall_o so that
//  the PC and IF/ID hold. A taken-branch flush from EX zeroes the stage, and a saturating counter

---
 rtl/id_ex_stage.sv | 98 +++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard or branch flush, and a saturating stall-cycle counter.
module id_ex_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [12:0]           id_ctrl_i,
   input  logic [5:0]            id_funct_i,
   input  logic [DATA_W-1:0]     id_rs_data_i,
   input  logic [DATA_W-1:0]     id_rt_data_i,
   input  logic [DATA_W-1:0]     id_imm_i,
   input  logic [DATA_W-1:0]     id_pc4_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   output logic [12:0]           ex_ctrl_o,
   output logic [5:0]            ex_funct_o,
   output logic [DATA_W-1:0]     ex_rs_data_o,
   output logic [DATA_W-1:0]     ex_rt_data_o,
   output logic [DATA_W-1:0]     ex_imm_o,
   output logic [DATA_W-1:0]     ex_pc4_o,
   output logic [REG_ADDR_W-1:0] ex_rs_o,
   output logic [REG_ADDR_W-1:0] ex_rt_o,
   output logic [REG_ADDR_W-1:0] ex_rd_o,
   output logic                  ex_valid_o,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   localparam int unsigned ALU_SRC2 = 12;
   localparam int unsigned DM_READ  = 8;
   localparam int unsigned DM_WRITE = 7;

   logic rt_is_src;
   logic rs_match;
   logic rt_match;
   logic hazard;
   logic bubble;

   // rt is only a source for R-type/BEQ (register second operand) and SW (store data).
   always_comb begin
      rt_is_src = ~id_ctrl_i[ALU_SRC2] | id_ctrl_i[DM_WRITE];
      rs_match  = (ex_rt_o == id_rs_i);
      rt_match  = (ex_rt_o == id_rt_i) & rt_is_src;
      hazard    = ex_valid_o & ex_ctrl_o[DM_READ] & (ex_rt_o != '0) & (rs_match | rt_match);
      bubble    = flush_i | hazard;
   end

   assign stall_o = hazard & ~flush_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ex_ctrl_o    <= '0;
         ex_funct_o   <= '0;
         ex_rs_data_o <= '0;
         ex_rt_data_o <= '0;
         ex_imm_o     <= '0;
         ex_pc4_o     <= '0;
         ex_rs_o      <= '0;
         ex_rt_o      <= '0;
         ex_rd_o      <= '0;
         ex_valid_o   <= 1'b0;
         stall_cnt_o  <= '0;
      end else begin
         if (bubble) begin
            ex_ctrl_o    <= '0;
            ex_funct_o   <= '0;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_pc4_o     <= '0;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_rd_o      <= '0;
            ex_valid_o   <= 1'b0;
         end else begin
            ex_ctrl_o    <= id_ctrl_i;
            ex_funct_o   <= id_funct_i;
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_pc4_o     <= id_pc4_i;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_rd_o      <= id_rd_i;
            ex_valid_o   <= 1'b1;
         end
         if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX state into a queue,
// a monitor pops and compares against the DUT each cycle.
module tb_id_ex_stage;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;

   localparam logic [12:0] C_ADDI = 13'b1_0_0_0_0_0_1_001000;
   localparam logic [12:0] C_LW   = 13'b1_0_1_0_1_0_1_100011;
   localparam logic [12:0] C_ADD  = 13'b0_1_0_0_0_0_1_000000;
   localparam logic [12:0] C_SW   = 13'b1_0_0_0_0_1_0_101011;
   localparam logic [12:0] C_BEQ  = 13'b0_0_0_1_0_0_0_000100;

   logic          clk = 1'b0;
   logic          rst_i, flush_i;
   logic [12:0]   id_ctrl_i;
   logic [5:0]    id_funct_i;
   logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i;
   logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic [12:0]   ex_ctrl_o;
   logic [5:0]    ex_funct_o;
   logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
   logic [AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
   logic          ex_valid_o, stall_o;
   logic [CW-1:0] stall_cnt_o;

   id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .id_ctrl_i(id_ctrl_i), .id_funct_i(id_funct_i),
      .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
      .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .ex_ctrl_o(ex_ctrl_o), .ex_funct_o(ex_funct_o),
      .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
      .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o),
      .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
      .ex_valid_o(ex_valid_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0]   ctrl;
      logic [5:0]    funct;
      logic [DW-1:0] rs_d, rt_d, imm, pc4;
      logic [AW-1:0] rs, rt, rd;
      logic          valid;
   } instr_t;

   typedef struct {
      logic   chk_stall;
      logic   stall;
      instr_t ex;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   instr_t        m_ex;
   logic [CW-1:0] m_cnt;
   bit            m_known = 0;
   bit            last_stall = 0;
   int unsigned   n_vec = 0;
   int unsigned   n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic instr_t mk(input logic [12:0] ctrl, input logic [5:0] funct,
                                 input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic [AW-1:0] rd);
      instr_t i;
      i.ctrl  = ctrl;
      i.funct = funct;
      i.rs_d  = $urandom;
      i.rt_d  = $urandom;
      i.imm   = $urandom;
      i.pc4   = $urandom;
      i.rs    = rs;
      i.rt    = rt;
      i.rd    = rd;
      i.valid = 1'b0;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      logic [12:0] c;
      case ($urandom_range(0, 5))
         0: c = C_ADDI;
         1, 2: c = C_LW;
         3: c = C_ADD;
         4: c = C_SW;
         default: c = C_BEQ;
      endcase
      return mk(c, 6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)));
   endfunction

   // Reference: a load in EX blocks any ID instruction that reads its destination.
   task automatic apply(input logic rst, input logic flush, input instr_t id);
      exp_t e;
      bit   load_in_ex, reads_rt, hz;
      @(negedge clk);
      rst_i = rst; flush_i = flush;
      id_ctrl_i = id.ctrl; id_funct_i = id.funct;
      id_rs_data_i = id.rs_d; id_rt_data_i = id.rt_d;
      id_imm_i = id.imm; id_pc4_i = id.pc4;
      id_rs_i = id.rs; id_rt_i = id.rt; id_rd_i = id.rd;
      #1;
      load_in_ex  = m_ex.valid && m_ex.ctrl[8];
      reads_rt    = !id.ctrl[12] || id.ctrl[7];
      hz          = load_in_ex && (m_ex.rt != 0) &&
                    ((m_ex.rt == id.rs) || (reads_rt && m_ex.rt == id.rt));
      e.chk_stall = m_known;
      e.stall     = hz && !flush;
      if (!rst) begin
         m_ex    = '0;
         m_cnt   = '0;
         m_known = 1;
      end else begin
         if (flush || hz) m_ex = '0;
         else begin
            m_ex = id;
            m_ex.valid = 1'b1;
         end
         if (e.stall && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      e.ex  = m_ex;
      e.cnt = m_cnt;
      sb.push_back(e);
      last_stall = e.stall;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_stall) check("stall", 64'(stall_o), 64'(e.stall));
            @(posedge clk);
            #1;
            check("ctrl",    64'(ex_ctrl_o),    64'(e.ex.ctrl));
            check("funct",   64'(ex_funct_o),   64'(e.ex.funct));
            check("rs_data", 64'(ex_rs_data_o), 64'(e.ex.rs_d));
            check("rt_data", 64'(ex_rt_data_o), 64'(e.ex.rt_d));
            check("imm",     64'(ex_imm_o),     64'(e.ex.imm));
            check("pc4",     64'(ex_pc4_o),     64'(e.ex.pc4));
            check("rs",      64'(ex_rs_o),      64'(e.ex.rs));
            check("rt",      64'(ex_rt_o),      64'(e.ex.rt));
            check("rd",      64'(ex_rd_o),      64'(e.ex.rd));
            check("valid",   64'(ex_valid_o),   64'(e.ex.valid));
            check("cnt",     64'(stall_cnt_o),  64'(e.cnt));
         end
      end
   end

   initial begin : stimulus
      instr_t id, add_i, lw_i;
      m_ex  = '0;
      m_cnt = '0;
      rst_i = 1'b0; flush_i = 1'b0;

      repeat (2) apply(1'b0, 1'($urandom), rand_instr());

      id = mk(C_ADDI, 6'h00, 5'd3, 5'd7, 5'd0);
      id.imm = 32'h0000_0005;
      apply(1'b1, 1'b0, id);

      lw_i  = mk(C_LW, 6'h00, 5'd1, 5'd2, 5'd0);
      add_i = mk(C_ADD, 6'h20, 5'd2, 5'd4, 5'd8);
      apply(1'b1, 1'b0, lw_i);
      apply(1'b1, 1'b0, add_i);
      apply(1'b1, 1'b0, add_i);
      @(posedge clk); #2;
      check("cnt_after_load_use", 64'(stall_cnt_o), 64'd1);

      apply(1'b1, 1'b0, lw_i);
      apply(1'b1, 1'b0, mk(C_ADDI, 6'h00, 5'd5, 5'd2, 5'd0));
      apply(1'b1, 1'b0, mk(C_LW, 6'h00, 5'd1, 5'd0, 5'd0));
      apply(1'b1, 1'b0, mk(C_ADD, 6'h20, 5'd0, 5'd0, 5'd9));
      apply(1'b1, 1'b0, mk(C_LW, 6'h00, 5'd1, 5'd6, 5'd0));
      id = mk(C_SW, 6'h00, 5'd1, 5'd6, 5'd0);
      apply(1'b1, 1'b0, id);
      apply(1'b1, 1'b0, id);

      apply(1'b1, 1'b0, mk(C_LW, 6'h00, 5'd1, 5'd3, 5'd0));
      apply(1'b1, 1'b1, mk(C_ADD, 6'h20, 5'd3, 5'd1, 5'd4));

      id = mk(C_LW, 6'h00, 5'd2, 5'd2, 5'd0);
      apply(1'b1, 1'b0, id);
      for (int i = 0; i < 20; i++) begin
         apply(1'b1, 1'b0, id);
         apply(1'b1, 1'b0, id);
      end
      @(posedge clk); #2;
      check("cnt_saturated", 64'(stall_cnt_o), 64'hF);
      apply(1'b0, 1'b0, id);
      @(posedge clk); #2;
      check("cnt_after_reset", 64'(stall_cnt_o), 64'd0);

      for (int i = 0; i < 400; i++) begin
         if (!last_stall) id = rand_instr();
         apply(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1,
               ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, id);
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      if (sb.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain actual=%0d required=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
